// File: rtl/ghost_wall_collision.sv
// ghost_wall_collision
// Watches ghost/wall drawing-request overlaps during a frame, classifies each
// overlap by the ghost edge zone it lands in (TOP/BOTTOM/LEFT/RIGHT), and at
// every startOfFrame presents the previous frame's result as collision plus
// HitEdgeCode (0 TOP, 1 BOTTOM, 2 LEFT, 3 RIGHT, 4 CORNER). After a reported
// hit, overlaps are ignored for HOLDOFF_FRAMES frames.
// Optional debug build: define GHOST_COLL_DEBUG_EN to add the edgeMask and
// hitCount observation ports.
module ghost_wall_collision #(
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HIGHT_Y = 32,
  parameter int EDGE_BAND      = 4,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  input  logic signed [10:0] ghostTopLeftX,
  input  logic signed [10:0] ghostTopLeftY,
  input  logic               ghostDR,
  input  logic               wallDR,
  output logic               collision,
  output logic [2:0]         HitEdgeCode
`ifdef GHOST_COLL_DEBUG_EN
  ,
  output logic [3:0]         edgeMask,
  output logic [7:0]         hitCount
`endif
);

  localparam logic [2:0] CODE_TOP    = 3'd0;
  localparam logic [2:0] CODE_BOTTOM = 3'd1;
  localparam logic [2:0] CODE_LEFT   = 3'd2;
  localparam logic [2:0] CODE_RIGHT  = 3'd3;
  localparam logic [2:0] CODE_CORNER = 3'd4;

  // Zone thresholds as 12-bit signed so the compares against the signed
  // offsets stay signed (a negative offset is never above a limit).
  localparam logic signed [11:0] BAND_LIM   = 12'(EDGE_BAND);
  localparam logic signed [11:0] BOTTOM_LIM = 12'(OBJECT_HIGHT_Y - EDGE_BAND);
  localparam logic signed [11:0] RIGHT_LIM  = 12'(OBJECT_WIDTH_X - EDGE_BAND);
  localparam logic [2:0]         HOLD_LOAD  = 3'(HOLDOFF_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         mask;        // {R,L,B,T} accumulated over the current frame
  logic [2:0]         holdoff_cnt;

  logic signed [11:0] off_x;
  logic signed [11:0] off_y;
  logic               overlap;
  logic [3:0]         zone;
  logic               enc_col;
  logic [2:0]         enc_code;

  // Pixel offset inside the ghost bitmap, sign-extended to 12 bits.
  assign off_x   = {pixelX[10], pixelX} - {ghostTopLeftX[10], ghostTopLeftX};
  assign off_y   = {pixelY[10], pixelY} - {ghostTopLeftY[10], ghostTopLeftY};
  assign overlap = ghostDR & wallDR;

  // Edge-zone bits for this pixel; an interior overlap yields zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    zone = 4'b0000;
    if (overlap) begin
      zone[0] = (off_y <  BAND_LIM);
      zone[1] = (off_y >= BOTTOM_LIM);
      zone[2] = (off_x <  BAND_LIM);
      zone[3] = (off_x >= RIGHT_LIM);
    end
  end

  // Encode the accumulated frame mask into collision and edge code.
  always_comb begin
    enc_col  = |mask;
    enc_code = CODE_TOP;
    if ($countones(mask) > 1) enc_code = CODE_CORNER;
    else if (mask[1])         enc_code = CODE_BOTTOM;
    else if (mask[2])         enc_code = CODE_LEFT;
    else if (mask[3])         enc_code = CODE_RIGHT;
  end

  // Frame state machine: accumulate, report at startOfFrame, hold off.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (reset) begin
      state       <= IDLE;
      mask        <= 4'b0000;
      holdoff_cnt <= 3'd0;
      collision   <= 1'b0;
      HitEdgeCode <= CODE_TOP;
    end else begin
      unique case (state)
        IDLE: begin
          if (startOfFrame) begin
            mask  <= 4'b0000;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (startOfFrame) begin
            collision   <= enc_col;
            HitEdgeCode <= enc_code;
            // The overlap on the SOF cycle belongs to the new frame.
            mask        <= zone;
            if (enc_col && (HOLDOFF_FRAMES > 0)) begin
              mask        <= 4'b0000;
              holdoff_cnt <= HOLD_LOAD;
              state       <= HOLDOFF;
            end
          end else begin
            mask <= mask | zone;
          end
        end
        HOLDOFF: begin
          mask <= 4'b0000;
          if (startOfFrame) begin
            collision   <= 1'b0;
            HitEdgeCode <= CODE_TOP;
            holdoff_cnt <= holdoff_cnt - 3'd1;
            if (holdoff_cnt <= 3'd1) state <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GHOST_COLL_DEBUG_EN
  // Debug observation: mask seen at each SOF and a saturating hit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      edgeMask <= 4'b0000;
      hitCount <= 8'd0;
    end else if (startOfFrame) begin
      edgeMask <= mask;
      if ((state == ACCUM) && enc_col && (hitCount != 8'hFF))
        hitCount <= hitCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ghost_wall_collision.sv
// tb_ghost_wall_collision
// Directed frames drive two instances (HOLDOFF_FRAMES=2 and 0) in parallel.
// Each startOfFrame pushes the hand-computed result for both into queues; a
// monitor pops at every SOF and compares the held outputs on every cycle.
module tb_ghost_wall_collision;

  typedef struct packed {
    logic       col;
    logic [2:0] code;
  } exp_t;

  localparam logic signed [10:0] GX = 11'sd100;
  localparam logic signed [10:0] GY = 11'sd50;

  logic               clk = 1'b0;
  logic               reset;
  logic               startOfFrame;
  logic signed [10:0] pixelX, pixelY;
  logic signed [10:0] ghostTopLeftX, ghostTopLeftY;
  logic               ghostDR, wallDR;
  logic               col_a, col_b;
  logic [2:0]         code_a, code_b;
`ifdef GHOST_COLL_DEBUG_EN
  logic [3:0]         emask_a, emask_b;
  logic [7:0]         hits_a, hits_b;
`endif

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ghost_wall_collision #(.HOLDOFF_FRAMES(2)) dut_a (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .ghostTopLeftX(ghostTopLeftX), .ghostTopLeftY(ghostTopLeftY),
    .ghostDR(ghostDR), .wallDR(wallDR),
    .collision(col_a), .HitEdgeCode(code_a)
`ifdef GHOST_COLL_DEBUG_EN
    , .edgeMask(emask_a), .hitCount(hits_a)
`endif
  );

  ghost_wall_collision #(.HOLDOFF_FRAMES(0)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .ghostTopLeftX(ghostTopLeftX), .ghostTopLeftY(ghostTopLeftY),
    .ghostDR(ghostDR), .wallDR(wallDR),
    .collision(col_b), .HitEdgeCode(code_b)
`ifdef GHOST_COLL_DEBUG_EN
    , .edgeMask(emask_b), .hitCount(hits_b)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; inputs change right after the falling edge.
  task automatic cyc(input bit sof, input int ox, input int oy, input bit g, input bit w);
    startOfFrame = sof;
    pixelX       = 11'(GX + ox);
    pixelY       = 11'(GY + oy);
    ghostDR      = g;
    wallDR       = w;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ov(input int ox, input int oy);
    cyc(0, ox, oy, 1, 1);
  endtask

  // SOF cycle: queue the expected report of both instances, optionally with
  // an overlap pixel on the same cycle.
  task automatic sof(input bit ca, input int cda, input bit cb, input int cdb,
                     input bit o = 0, input int ox = 0, input int oy = 0);
    q_a.push_back(exp_t'{ca, 3'(cda)});
    q_b.push_back(exp_t'{cb, 3'(cdb)});
    cyc(1, ox, oy, o, o);
  endtask

  // Monitor: new expectation on SOF (or zero on reset), compare every cycle.
  initial begin
    exp_t ea, eb;
    ea = '0;
    eb = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        ea = '0;
        eb = '0;
      end else if (startOfFrame) begin
        if (q_a.size() == 0) check("queue_a_underflow", 1, 0);
        else ea = q_a.pop_front();
        if (q_b.size() == 0) check("queue_b_underflow", 1, 0);
        else eb = q_b.pop_front();
      end
      @(negedge clk);
      check("a_collision",   int'(col_a),  int'(ea.col));
      check("a_HitEdgeCode", int'(code_a), int'(ea.code));
      check("b_collision",   int'(col_b),  int'(eb.col));
      check("b_HitEdgeCode", int'(code_b), int'(eb.code));
    end
  end

  initial begin
    ghostTopLeftX = GX;
    ghostTopLeftY = GY;
    reset         = 1'b1;
    startOfFrame  = 1'b0;
    pixelX        = GX;
    pixelY        = GY;
    ghostDR       = 1'b0;
    wallDR        = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Three empty frames after leaving IDLE.
    sof(0, 0, 0, 0); idle(3);                         // 1 IDLE->ACCUM
    sof(0, 0, 0, 0); idle(3);                         // 2
    sof(0, 0, 0, 0); idle(3);                         // 3
    sof(0, 0, 0, 0); ov(16, 1); idle(2);              // 4 TOP overlap
    sof(1, 0, 1, 0);                                  // 5 report TOP; A holds off
`ifdef GHOST_COLL_DEBUG_EN
    check("a_edgeMask_top", int'(emask_a), 1);
    check("b_edgeMask_top", int'(emask_b), 1);
`endif
    ov(16, 1); idle(2);
    sof(0, 0, 1, 0); ov(16, 1); idle(2);              // 6 A holdoff, B back-to-back
    sof(0, 0, 1, 0); ov(30, 16); ov(16, 30); idle(2); // 7 A back in ACCUM; R+B
    sof(1, 4, 1, 4); ov(1, 1); idle(2);               // 8 CORNER
    sof(0, 0, 1, 4); idle(3);                         // 9 single pixel T+L
    sof(0, 0, 0, 0); ov(1, 1); idle(2);               // 10 A ACCUM
    sof(1, 4, 1, 4); idle(3);                         // 11
    sof(0, 0, 0, 0); idle(3);                         // 12
    sof(0, 0, 0, 0);                                  // 13 A ACCUM; interior and non-overlaps
    ov(16, 16); ov(16, 4); ov(27, 16); ov(4, 16); ov(16, 27);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 1, 0); idle(2);
    sof(0, 0, 0, 0); idle(3);                         // 14 nothing reported
    sof(0, 0, 0, 0, 1, 31, 10); idle(3);              // 15 RIGHT pixel on SOF cycle
    sof(1, 3, 1, 3); idle(3);                         // 16 RIGHT reported now
    sof(0, 0, 0, 0); idle(3);                         // 17
    sof(0, 0, 0, 0); ov(0, 16); idle(2);              // 18 LEFT
    sof(1, 2, 1, 2); ov(16, 31); idle(2);             // 19 BOTTOM (B only)
    sof(0, 0, 1, 1); idle(3);                         // 20
    sof(0, 0, 0, 0); ov(16, 0); idle(1);              // 21 TOP then mid-frame reset
    reset = 1'b1; idle(1); reset = 1'b0; idle(2);
    sof(0, 0, 0, 0); ov(16, 0); idle(2);              // 22 IDLE->ACCUM, TOP
    sof(1, 0, 1, 0); idle(3);                         // 23 reports normally
    sof(0, 0, 0, 0); idle(3);                         // 24
    sof(0, 0, 0, 0); idle(2);                         // 25 A back in ACCUM

`ifdef GHOST_COLL_DEBUG_EN
    // 300 reported TOP hits on the no-holdoff instance saturate its counter.
    for (int k = 0; k <= 300; k++) begin
      sof((k >= 1) && (((k - 1) % 3) == 0), 0, k >= 1, 0);
      ov(16, 1);
    end
    idle(1);
    check("b_hitCount_saturated", int'(hits_b), 255);
`endif

    idle(2);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
